// File: rtl/esfa_memory_cell_p.sv
// esfa_memory_cell_p: single-entry array/element memory cell.
// A request is captured in IDLE, evaluated against the stored fields in EXEC,
// and its response is held in RESP until the consumer takes it. Field updates
// are committed on the EXEC exit edge only when the captured op_write is set.
module esfa_memory_cell_p #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [2:0]   op_code,
  input  logic         op_write,
  input  logic [W-1:0] handle,
  input  logic [W-1:0] ins_index,
  input  logic [W-1:0] ins_value,
  input  logic [W-1:0] metadata,
  input  logic         is_metadata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_bool,
  output logic [W-1:0] rsp_value,
  output logic [W-1:0] rsp_context,
  output logic         occupied
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_UPDATE   = 3'd0;
  localparam logic [2:0] OP_LOOKUP   = 3'd1;
  localparam logic [2:0] OP_ENCODE   = 3'd2;
  localparam logic [2:0] OP_RANGE    = 3'd3;
  localparam logic [2:0] OP_DELETE   = 3'd4;
  localparam logic [2:0] OP_MARKAVL  = 3'd5;
  localparam logic [2:0] OP_ENRANK   = 3'd6;

  // Unsigned minimum of two words.
  function automatic logic [W-1:0] minU(input logic [W-1:0] a, input logic [W-1:0] b);
    minU = (a < b) ? a : b;
  endfunction

  // Unsigned maximum of two words.
  function automatic logic [W-1:0] maxU(input logic [W-1:0] a, input logic [W-1:0] b);
    maxU = (a > b) ? a : b;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [W-1:0] satInc(input logic [W-1:0] a);
    satInc = (a == {W{1'b1}}) ? a : (a + {{(W-1){1'b0}}, 1'b1});
  endfunction

  state_t         state_r;
  state_t         nextState_s;
  logic           opReady_r;
  logic           rspValid_r;
  logic           rspBool_r;
  logic [W-1:0]   rspValue_r;
  logic [W-1:0]   rspContext_r;

  // Captured request operands
  logic [2:0]     opCode_r;
  logic           opWrite_r;
  logic [W-1:0]   handle_r;
  logic [W-1:0]   insIndex_r;
  logic [W-1:0]   insValue_r;
  logic [W-1:0]   metaCap_r;
  logic           isMeta_r;

  // Stored cell fields
  logic           arrDef_r;
  logic [W-1:0]   arrayCode_r;
  logic           eltDef_r;
  logic [W-1:0]   rank_r;
  logic [W-1:0]   low_r;
  logic [W-1:0]   high_r;
  logic [W-1:0]   index_r;
  logic [W-1:0]   value_r;

  // Evaluation results and candidate field values
  logic           match_s;
  logic           hit_s;
  logic           evalBool_s;
  logic [W-1:0]   evalValue_s;
  logic [W-1:0]   evalContext_s;
  logic           nxtArrDef_s;
  logic [W-1:0]   nxtArrayCode_s;
  logic           nxtEltDef_s;
  logic [W-1:0]   nxtRank_s;
  logic [W-1:0]   nxtLow_s;
  logic [W-1:0]   nxtHigh_s;
  logic [W-1:0]   nxtIndex_s;
  logic [W-1:0]   nxtValue_s;
  logic [W-1:0]   newLow_s;
  logic [W-1:0]   newHigh_s;
  logic [W-1:0]   newRank_s;

  assign op_ready    = opReady_r;
  assign rsp_valid   = rspValid_r;
  assign rsp_bool    = rspBool_r;
  assign rsp_value   = rspValue_r;
  assign rsp_context = rspContext_r;
  assign occupied    = arrDef_r;

  // Next-state logic for the IDLE -> EXEC -> RESP handshake sequence.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (op_valid && opReady_r) begin
          nextState_s = EXEC;
        end else begin
          nextState_s = IDLE;
        end
      end
      EXEC: nextState_s = RESP;
      RESP: begin
        if (rspValid_r && rsp_ready) begin
          nextState_s = IDLE;
        end else begin
          nextState_s = RESP;
        end
      end
      default: nextState_s = IDLE;
    endcase
  end

  // State register; op_ready is registered so it tracks the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      opReady_r <= 1'b1;
    end else begin
      state_r   <= nextState_s;
      opReady_r <= (nextState_s == IDLE);
    end
  end

  // Capture all request operands on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opCode_r   <= 3'd0;
      opWrite_r  <= 1'b0;
      handle_r   <= '0;
      insIndex_r <= '0;
      insValue_r <= '0;
      metaCap_r  <= '0;
      isMeta_r   <= 1'b0;
    end else if (state_r == IDLE && op_valid && opReady_r) begin
      opCode_r   <= op_code;
      opWrite_r  <= op_write;
      handle_r   <= handle;
      insIndex_r <= ins_index;
      insValue_r <= ins_value;
      metaCap_r  <= metadata;
      isMeta_r   <= is_metadata;
    end
  end

  // Evaluate the captured op against the stored fields.
  always_comb begin
    match_s        = arrDef_r && (arrayCode_r == handle_r);
    hit_s          = match_s && eltDef_r && (index_r == insIndex_r);
    newLow_s       = minU(low_r, insIndex_r);
    newHigh_s      = maxU(high_r, insIndex_r);
    newRank_s      = satInc(rank_r);
    evalBool_s     = 1'b0;
    evalValue_s    = '0;
    evalContext_s  = '0;
    nxtArrDef_s    = arrDef_r;
    nxtArrayCode_s = arrayCode_r;
    nxtEltDef_s    = eltDef_r;
    nxtRank_s      = rank_r;
    nxtLow_s       = low_r;
    nxtHigh_s      = high_r;
    nxtIndex_s     = index_r;
    nxtValue_s     = value_r;
    case (opCode_r)
      OP_UPDATE: begin
        if (hit_s) begin
          evalBool_s    = 1'b1;
          evalValue_s   = value_r;
          evalContext_s = rank_r;
          nxtValue_s    = insValue_r;
        end else begin
          evalBool_s    = 1'b0;
        end
      end
      OP_LOOKUP: begin
        if (hit_s) begin
          evalBool_s    = 1'b1;
          evalValue_s   = value_r;
          evalContext_s = rank_r;
        end else begin
          evalBool_s    = 1'b0;
        end
      end
      OP_ENCODE: begin
        if (!arrDef_r) begin
          evalBool_s     = 1'b1;
          evalContext_s  = handle_r;
          nxtArrDef_s    = 1'b1;
          nxtArrayCode_s = handle_r;
          nxtEltDef_s    = 1'b1;
          nxtIndex_s     = insIndex_r;
          nxtValue_s     = insValue_r;
          nxtRank_s      = metaCap_r;
          nxtLow_s       = insIndex_r;
          nxtHigh_s      = insIndex_r;
        end else begin
          evalBool_s     = 1'b0;
        end
      end
      OP_RANGE: begin
        if (match_s) begin
          evalBool_s    = 1'b1;
          evalValue_s   = newLow_s;
          evalContext_s = newHigh_s;
          nxtLow_s      = newLow_s;
          nxtHigh_s     = newHigh_s;
        end else begin
          evalBool_s    = 1'b0;
        end
      end
      OP_DELETE: begin
        if (hit_s) begin
          evalBool_s  = 1'b1;
          evalValue_s = value_r;
          nxtEltDef_s = 1'b0;
          if (isMeta_r) begin
            nxtArrDef_s = 1'b0;
          end else begin
            nxtArrDef_s = arrDef_r;
          end
        end else begin
          evalBool_s  = 1'b0;
        end
      end
      OP_MARKAVL: begin
        if (match_s) begin
          evalBool_s     = 1'b1;
          nxtArrDef_s    = 1'b0;
          nxtArrayCode_s = '0;
          nxtEltDef_s    = 1'b0;
          nxtRank_s      = '0;
          nxtLow_s       = '0;
          nxtHigh_s      = '0;
          nxtIndex_s     = '0;
          nxtValue_s     = '0;
        end else begin
          evalBool_s     = 1'b0;
        end
      end
      OP_ENRANK: begin
        if (match_s && (rank_r >= metaCap_r)) begin
          evalBool_s    = 1'b1;
          evalContext_s = newRank_s;
          nxtRank_s     = newRank_s;
        end else begin
          evalBool_s    = 1'b0;
          evalContext_s = rank_r;
        end
      end
      default: begin
        // Reserved op: all-zero response, no field change.
        evalBool_s    = 1'b0;
        evalValue_s   = '0;
        evalContext_s = '0;
      end
    endcase
  end

  // Response registers: load on EXEC exit, hold in RESP until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rspValid_r   <= 1'b0;
      rspBool_r    <= 1'b0;
      rspValue_r   <= '0;
      rspContext_r <= '0;
    end else begin
      case (state_r)
        EXEC: begin
          rspValid_r   <= 1'b1;
          rspBool_r    <= evalBool_s;
          rspValue_r   <= evalValue_s;
          rspContext_r <= evalContext_s;
        end
        RESP: begin
          if (rspValid_r && rsp_ready) begin
            rspValid_r   <= 1'b0;
            rspBool_r    <= 1'b0;
            rspValue_r   <= '0;
            rspContext_r <= '0;
          end
        end
        default: begin
          rspValid_r <= 1'b0;
        end
      endcase
    end
  end

  // Cell fields: commit candidate values on EXEC exit for non-dry-run ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arrDef_r    <= 1'b0;
      arrayCode_r <= '0;
      eltDef_r    <= 1'b0;
      rank_r      <= '0;
      low_r       <= '0;
      high_r      <= '0;
      index_r     <= '0;
      value_r     <= '0;
    end else if (state_r == EXEC && opWrite_r) begin
      arrDef_r    <= nxtArrDef_s;
      arrayCode_r <= nxtArrayCode_s;
      eltDef_r    <= nxtEltDef_s;
      rank_r      <= nxtRank_s;
      low_r       <= nxtLow_s;
      high_r      <= nxtHigh_s;
      index_r     <= nxtIndex_s;
      value_r     <= nxtValue_s;
    end
  end

endmodule

// File: doc/esfa_memory_cell_p.md
ESFA_MEMORY_CELL_P -- requirements
Module: esfa_memory_cell_p

Interface
REQ-001 SHALL have parameter W, default 8: width of handle, index, value, metadata, rank, low, high and all result words.
REQ-002 SHALL have ports `clk` (in, 1) and `rst_n` (in, 1); one clock, and `rst_n` is an asynchronous, active-low reset.
REQ-003 SHALL have these request-side ports:
- `op_valid` (in, 1): request valid.
- `op_ready` (out, 1): cell can accept a request.
- `op_code` (in, 3): operation select.
- `op_write` (in, 1): commit state changes; 0 = dry run.
- `handle` (in, W): array code operand.
- `ins_index` (in, W): index operand.
- `ins_value` (in, W): value operand.
- `metadata` (in, W): rank/threshold operand.
- `is_metadata` (in, 1): operand modifier.
REQ-004 SHALL have these response-side and status ports:
- `rsp_valid` (out, 1): response valid.
- `rsp_ready` (in, 1): consumer accepts the response.
- `rsp_bool` (out, 1): hit/success flag.
- `rsp_value` (out, W): result value.
- `rsp_context` (out, W): result context.
- `occupied` (out, 1): equals internal arr_def.

Function
REQ-005 SHALL hold internal registers arr_def(1), array_code(W), elt_def(1), rank(W), low(W), high(W), index(W), value(W).
REQ-006 SHALL implement the FSM IDLE -> EXEC -> RESP -> IDLE.
- op_ready=1 only in IDLE.
- A request is accepted on an edge with op_valid&&op_ready; all operands are captured at that edge and the FSM enters EXEC.
REQ-007 SHALL, on the edge leaving EXEC:
- evaluate the captured op against the current fields;
- register the rsp_* outputs and set rsp_valid=1;
- apply field updates only if the captured op_write=1.
Latency: rsp_valid is visible 2 edges after the accept edge.
REQ-008 SHALL hold rsp_* stable in RESP until rsp_valid&&rsp_ready at an edge, then return to IDLE with rsp_valid=0; back-to-back issue rate is one op per 3 cycles minimum.
REQ-009 SHALL define match = arr_def && array_code==handle, and hit = match && elt_def && index==ins_index.
REQ-010 op 0 UPDATE SHALL behave as follows:
- On hit: bool=1, value_out = old value, context=rank; write value<=ins_value.
- Else: bool=0.
REQ-011 op 1 LOOKUP SHALL behave as follows:
- On hit: bool=1, value_out=value, context=rank.
- Else: bool=0.
- Never modifies fields.
REQ-012 op 2 ENCODE SHALL behave as follows:
- If !arr_def: bool=1, context=handle; write arr_def=1, array_code=handle, elt_def=1, index=ins_index, value=ins_value, rank=metadata, low=high=ins_index.
- If arr_def: bool=0, no change.
REQ-013 op 3 RANGE_EXTEND SHALL behave as follows:
- If match: write low=min(low,ins_index), high=max(high,ins_index); bool=1, value_out=new low, context=new high.
- Else: bool=0.
REQ-014 op 4 DELETE SHALL behave as follows:
- If hit: write elt_def=0; if also is_metadata=1, write arr_def=0; bool=1, value_out=old value.
- Else: bool=0.
REQ-015 op 5 MARK_AVAILABLE SHALL behave as follows:
- If match: clear all fields to 0; bool=1.
- Else: bool=0.
REQ-016 op 6 ENRANK SHALL behave as follows:
- If match && rank>=metadata (unsigned): write rank=rank+1, saturating at 2^W-1; bool=1, context=new rank.
- Else: bool=0, context=rank.
REQ-017 op 7 SHALL be reserved: bool=0, value=0, context=0, no field change.
REQ-018 SHALL set rsp_value and rsp_context to 0 wherever the op definition does not specify them, including on every bool=0 result unless stated otherwise.
REQ-019 SHALL, when op_write=0, produce exactly the response op_write=1 would produce, with no field change.
REQ-020 SHALL use unsigned comparisons throughout, with no wrap in ENRANK.

Reset
REQ-021 SHALL, while rst_n=0, force:
- FSM=IDLE, op_ready=1 (after reset release), rsp_valid=0;
- rsp_bool=0, rsp_value=0, rsp_context=0;
- all internal fields 0, occupied=0.
REQ-022 SHALL, on reset asserted mid-operation (EXEC or RESP), abort the op with no field write and no response; the first edge after release may accept a new request.

Verification
REQ-023 ENCODE (handle=3, idx=5, val=0x2A, meta=1, write=1) on an empty cell -> 2 edges later rsp_valid=1, bool=1, context=3; occupied=1.
REQ-024 After REQ-023, LOOKUP (h=3, idx=5) -> bool=1, value=0x2A, context=1; LOOKUP (h=4, idx=5) -> bool=0, value=0.
REQ-025 UPDATE (h=3, idx=5, val=0x55, write=0) -> bool=1, value=0x2A; then LOOKUP -> value=0x2A (no change). Repeat with write=1 -> subsequent LOOKUP value=0x55.
REQ-026 ENRANK with rank=0xFF, meta=0 -> bool=1, context=0xFF (saturation); RANGE_EXTEND idx=9 then idx=2 -> low=2, high=9.
REQ-027 Hold rsp_ready=0 for 5 cycles -> rsp_* stable and op_ready=0 throughout; pulse rsp_ready -> op_ready=1 next cycle.
REQ-028 Assert rst_n=0 in EXEC of an UPDATE -> no response, fields all 0, occupied=0; DELETE (is_metadata=1) on a hit -> occupied=0.
